// File: rtl/demo_input_ctrl.sv
// demo_input_ctrl: button/switch front end for the demo top.
// Debounces the push button and runs one start/ack/done handshake per press.
module demo_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_raw,
  input  logic       sw_d1_mode,
  input  logic       sw_d2_mode,
  input  logic       sw_d1_en,
  input  logic       sw_d2_en,
  input  logic       d1_ready,
  input  logic       d2_ready,
  output logic       start,
  output logic       d1_mode,
  output logic       d2_mode,
  output logic       d1_en,
  output logic       d2_en,
  output logic       busy,
  output logic       timeout,
  output logic [7:0] op_count
);

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  ST_LAST = 4'(START_CYCLES - 1);
  localparam logic [20:0] TO_LAST = 21'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    ACK,
    DONE
  } state_t;

  logic [4:0] sync1, sync2;
  logic       btn_s, m1_s, m2_s, e1_s, e2_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_raw, sw_d1_mode, sw_d2_mode, sw_d1_en, sw_d2_en};
      sync2 <= sync1;
    end
  end

  assign {btn_s, m1_s, m2_s, e1_s, e2_s} = sync2;

  logic [15:0] db_cnt;
  logic        db_level, db_prev, press_evt;

  // Any sample matching the current level restarts the stability count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
    end else begin
      db_prev <= db_level;
      if (btn_s == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= btn_s;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end
    end
  end

  assign press_evt = db_level & ~db_prev;

  state_t      state, state_d;
  logic [3:0]  st_cnt, st_cnt_d;
  logic [20:0] to_cnt, to_cnt_d;
  logic [3:0]  cap, cap_d;
  logic        start_d, timeout_d;
  logic [7:0]  op_count_d;
  logic        ack_low, can_go;

  assign ack_low = (d1_en & ~d1_ready) | (d2_en & ~d2_ready);
  assign can_go  = d1_ready & d2_ready & (e1_s | e2_s);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      st_cnt   <= '0;
      to_cnt   <= '0;
      cap      <= '0;
      start    <= 1'b0;
      timeout  <= 1'b0;
      op_count <= '0;
    end else begin
      state    <= state_d;
      st_cnt   <= st_cnt_d;
      to_cnt   <= to_cnt_d;
      cap      <= cap_d;
      start    <= start_d;
      timeout  <= timeout_d;
      op_count <= op_count_d;
    end
  end

  always_comb begin
    state_d    = state;
    st_cnt_d   = st_cnt;
    to_cnt_d   = to_cnt;
    cap_d      = cap;
    start_d    = start;
    timeout_d  = timeout;
    op_count_d = op_count;
    unique case (state)
      IDLE: begin
        if (press_evt && can_go) begin
          state_d  = START;
          start_d  = 1'b1;
          st_cnt_d = '0;
          cap_d    = {m1_s, m2_s, e1_s, e2_s};
        end
      end
      START: begin
        if (st_cnt == ST_LAST) begin
          state_d  = ACK;
          start_d  = 1'b0;
          to_cnt_d = '0;
        end else begin
          st_cnt_d = st_cnt + 4'd1;
        end
      end
      ACK: begin
        to_cnt_d = to_cnt + 21'd1;
        if (to_cnt == TO_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (ack_low || to_cnt == 21'd1) begin
          // to_cnt==1 means two cycles here with no ready drop
          state_d = DONE;
        end
      end
      DONE: begin
        to_cnt_d = to_cnt + 21'd1;
        if (to_cnt == TO_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (d1_ready && d2_ready) begin
          state_d    = IDLE;
          op_count_d = op_count + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign {d1_mode, d2_mode, d1_en, d2_en} = cap;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_demo_input_ctrl.sv
// tb_demo_input_ctrl: directed + randomized checks of demo_input_ctrl
// against a transaction-level model of presses and completed operations.
module tb_demo_input_ctrl;

  localparam int DB = 4;
  localparam int SC = 2;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic btn_raw = 1'b0;
  logic sw_d1_mode = 1'b0, sw_d2_mode = 1'b0;
  logic sw_d1_en = 1'b0, sw_d2_en = 1'b0;
  logic d1_ready, d2_ready;
  logic start, d1_mode, d2_mode, d1_en, d2_en, busy, timeout;
  logic [7:0] op_count;

  logic rd1 = 1'b1, rd2 = 1'b1, blk1 = 1'b0, blk2 = 1'b0;
  int resp_low = 2;
  int n_assert = 0;
  int n_fail = 0;
  int start_rises = 0;
  int exp_ops = 0;
  logic exp_to = 1'b0;
  logic [3:0] exp_cap = 4'b0;

  assign d1_ready = rd1 & ~blk1;
  assign d2_ready = rd2 & ~blk2;

  demo_input_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .START_CYCLES(SC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .btn_raw(btn_raw),
    .sw_d1_mode(sw_d1_mode),
    .sw_d2_mode(sw_d2_mode),
    .sw_d1_en(sw_d1_en),
    .sw_d2_en(sw_d2_en),
    .d1_ready(d1_ready),
    .d2_ready(d2_ready),
    .start(start),
    .d1_mode(d1_mode),
    .d2_mode(d2_mode),
    .d1_en(d1_en),
    .d2_en(d2_en),
    .busy(busy),
    .timeout(timeout),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  always @(posedge start) start_rises++;

  // Downstream stand-in: enabled masters go busy when start is seen.
  initial forever begin
    @(negedge clk);
    if (start) begin
      if (d1_en) rd1 = 1'b0;
      if (d2_en) rd2 = 1'b0;
      if (resp_low >= 0) begin
        repeat (resp_low) @(negedge clk);
      end else begin
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
      end
      rd1 = 1'b1;
      rd2 = 1'b1;
      for (int i = 0; i < 50 && start; i++) @(negedge clk);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int v,
                         input int lo, input int hi);
    n_assert++;
    assert (v >= lo && v <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic check_outs();
    chk("op_count", {24'd0, op_count}, exp_ops % 256);
    chk("timeout", timeout, exp_to);
    chk("captured", {d1_mode, d2_mode, d1_en, d2_en}, exp_cap);
    chk("busy_idle", busy, 1'b0);
  endtask

  task automatic do_op(input logic m1, input logic e1,
                       input logic m2, input logic e2,
                       input logic b1, input logic b2, input int low);
    int lat, w, el, r0;
    bit seen, acc;
    sw_d1_mode = m1;
    sw_d1_en = e1;
    sw_d2_mode = m2;
    sw_d2_en = e2;
    blk1 = b1;
    blk2 = b2;
    resp_low = low;
    acc = !b1 && !b2 && (e1 || e2);
    r0 = start_rises;
    repeat (3) @(negedge clk);
    btn_raw = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      seen = start;
    end
    chk("accept", seen, acc);
    if (seen) begin
      chk_rng("latency", lat, DB + 2, DB + 4);
      exp_cap = {m1, m2, e1, e2};
      {sw_d1_mode, sw_d2_mode, sw_d1_en, sw_d2_en} = 4'($urandom);
      w = 0;
      for (int i = 0; i < 20 && start; i++) begin
        @(negedge clk);
        w++;
      end
      chk("start_width", w, SC);
      chk("captured_live", {d1_mode, d2_mode, d1_en, d2_en}, exp_cap);
      el = 0;
      for (int i = 0; i < 300 && busy; i++) begin
        @(negedge clk);
        el++;
      end
      chk("busy_drop", busy, 1'b0);
      if (low < 0) begin
        chk_rng("timeout_len", el, TO - 1, TO + 1);
        exp_to = 1'b1;
      end else begin
        exp_ops++;
      end
    end else begin
      repeat (5) @(negedge clk);
    end
    chk("start_count", start_rises - r0, acc ? 1 : 0);
    check_outs();
    btn_raw = 1'b0;
    blk1 = 1'b0;
    blk2 = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int r0, lat;
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_start", start, 1'b0);
    check_outs();
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    do_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);

    // bouncing button: 2-cycle toggles never satisfy the stability window
    sw_d1_mode = 1'b0;
    sw_d1_en = 1'b1;
    sw_d2_mode = 1'b1;
    sw_d2_en = 1'b0;
    resp_low = 2;
    r0 = start_rises;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      btn_raw = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    chk("bounce_quiet", start_rises - r0, 0);
    btn_raw = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      seen = start;
    end
    chk_rng("bounce_latency", lat, DB + 2, DB + 4);
    for (int i = 0; i < 100 && (busy || start); i++) @(negedge clk);
    exp_ops++;
    exp_cap = {1'b0, 1'b1, 1'b1, 1'b0};
    repeat (10) @(negedge clk);
    chk("bounce_one", start_rises - r0, 1);
    check_outs();
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);

    do_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2);
    do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);

    for (int k = 0; k < 16; k++) begin
      do_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            $urandom_range(1, 6));
    end

    do_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);

    // second press lands while the first op is still in flight
    sw_d1_mode = 1'b0;
    sw_d2_mode = 1'b0;
    sw_d1_en = 1'b1;
    sw_d2_en = 1'b1;
    resp_low = 30;
    r0 = start_rises;
    repeat (3) @(negedge clk);
    btn_raw = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = start;
    end
    chk("both_accept", seen, 1'b1);
    exp_cap = 4'b0011;
    btn_raw = 1'b0;
    repeat (8) @(negedge clk);
    btn_raw = 1'b1;
    repeat (10) @(negedge clk);
    chk("both_inflight", busy, 1'b1);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    exp_ops++;
    repeat (12) @(negedge clk);
    chk("both_single", start_rises - r0, 1);
    check_outs();
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);

    for (int k = 0; k < 256; k++) begin
      do_op(1'($urandom), 1'b1, 1'($urandom), 1'($urandom),
            1'b0, 1'b0, $urandom_range(1, 3));
    end

    // reset while start is high, button kept pressed across reset
    resp_low = 1;
    sw_d1_mode = 1'b1;
    sw_d1_en = 1'b1;
    sw_d2_mode = 1'b0;
    sw_d2_en = 1'b0;
    repeat (3) @(negedge clk);
    btn_raw = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = start;
    end
    chk("rst_seen", seen, 1'b1);
    rstn = 1'b0;
    #1;
    exp_ops = 0;
    exp_to = 1'b0;
    exp_cap = 4'b0;
    chk("rst_mid_start", start, 1'b0);
    check_outs();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    r0 = start_rises;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      seen = start;
    end
    chk("post_rst_start", seen, 1'b1);
    chk_rng("post_rst_latency", lat, DB + 2, DB + 4);
    exp_cap = {1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 100 && (busy || start); i++) @(negedge clk);
    exp_ops++;
    repeat (12) @(negedge clk);
    chk("post_rst_one", start_rises - r0, 1);
    check_outs();
    btn_raw = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/demo_input_ctrl.md
DEMO_INPUT_CTRL -- requirements
Module: demo_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable cycles required to accept a new button level (range 2..65535).
REQ-002 SHALL have parameter START_CYCLES, default 2, meaning width in clk cycles of each start pulse (range 1..15).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning maximum cycles from start deassertion to completion before abort (range 16..2^20).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 btn_raw  input  1  asynchronous, bouncy push button, active-high.
REQ-007 sw_d1_mode, sw_d2_mode, sw_d1_en, sw_d2_en  input  1 each  asynchronous slide switches: mode (1=write, 0=read) and enable per master.
REQ-008 d1_ready, d2_ready  input  1 each  ready flags from the downstream demo top; 1 = master idle.
REQ-009 start  output  1  registered start pulse to the downstream demo top.
REQ-010 d1_mode, d2_mode, d1_en, d2_en  output  1 each  registered mode/enable, captured per operation.
REQ-011 busy  output  1  high whenever FSM is not IDLE.
REQ-012 timeout  output  1  sticky flag, set on aborted operation.
REQ-013 op_count  output  8  completed-operation counter.

Function
REQ-014 SHALL pass btn_raw and the four switches each through a 2-flop synchronizer before any other use.
REQ-015 SHALL debounce synchronized button: counter resets on any change versus the current debounced level; debounced level updates only when new level held DEBOUNCE_CYCLES consecutive cycles.
REQ-016 SHALL generate press_evt, a single-cycle pulse on each 0->1 transition of the debounced level; releases generate no event.
REQ-017 SHALL implement FSM states IDLE, START, ACK, DONE.
REQ-018 IDLE -> START when press_evt and d1_ready and d2_ready and (sync d1_en or sync d2_en); same edge captures sync switches into d1_mode/d2_mode/d1_en/d2_en and asserts start.
REQ-019 press_evt in IDLE with either ready low or no enable set SHALL be dropped, no output change.
REQ-020 START: start held high exactly START_CYCLES cycles; then start low, -> ACK.
REQ-021 ACK: -> DONE when ready of any enabled master is low (operation accepted); -> DONE also if both enabled readies are already high after 2 cycles in ACK (fast completion).
REQ-022 DONE: -> IDLE when d1_ready and d2_ready both high; op_count increments by 1 on that edge, wrapping 255 -> 0.
REQ-023 Timeout counter SHALL clear on START->ACK, count in ACK and DONE; reaching TIMEOUT_CYCLES forces -> IDLE, sets timeout, no op_count increment.
REQ-024 Captured mode/en outputs SHALL hold through the operation and after return to IDLE, until the next accepted press.
REQ-025 press_evt outside IDLE SHALL be ignored, not queued; press_evt on the same edge as DONE->IDLE is ignored.
REQ-026 Switch changes outside the capture edge SHALL have no effect on outputs.
REQ-027 Latency: clean btn_raw rise to start high = 2 + DEBOUNCE_CYCLES + 1 cycles, tolerance +1 for sampling phase.
REQ-028 timeout SHALL clear only on reset.

Reset
REQ-029 rstn low SHALL asynchronously force: FSM IDLE, start 0, busy 0, timeout 0, op_count 0, d1/d2 mode/en 0, debounced level 0, synchronizers 0, all counters 0.
REQ-030 Reset mid-operation SHALL drop start within the same cycle; no op_count change; first post-reset press requires full debounce.
REQ-031 After rstn release, a button already held high SHALL produce exactly one press_evt after debounce.

Verification (DEBOUNCE_CYCLES=4, START_CYCLES=2, TIMEOUT_CYCLES=64)
REQ-032 Write on d1: sw_d1_en=1, sw_d1_mode=1, both ready; clean press -> start high 2 cycles, 7+/-1 cycles after press; d1_en=1, d1_mode=1, d2_en=0; d1_ready low then high -> op_count=1, busy low.
REQ-033 Bounce: btn_raw toggles every 2 cycles for 20 cycles, then holds high -> exactly one start pulse, after stable period.
REQ-034 Blocked press: d2_ready=0 or both enables 0, press -> no start, outputs unchanged, op_count unchanged.
REQ-035 Timeout: press accepted, d1_ready held low forever -> after 64 cycles FSM IDLE, timeout=1, op_count unchanged; next valid press still works, timeout stays 1.
REQ-036 Both masters: both en=1, modes=0; second press during DONE ignored; single op completes -> op_count +1; 256 ops -> op_count wraps to 0.
REQ-037 Reset mid-START: rstn low while start=1 -> start 0 immediately, all outputs at reset values.
